// File: rtl/leaf_pkg.sv
// Packet field widths, offsets and assembly shared by the leaf packetizer,
// the leaf interface and the depacketizer.
package leaf_pkg;

    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;
    localparam int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

    localparam int PAYLOAD_LSB = 0;
    localparam int ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_BITS;
    localparam int PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;
    localparam int VALID_BIT   = LEAF_LSB + NUM_LEAF_BITS;

    // Credits mirror remote BRAM freespace, so they need one bit above the address.
    localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
    localparam int CREDIT_MAX  = 1 << NUM_ADDR_BITS;

    typedef logic [PACKET_BITS-1:0] packet_t;

    function automatic packet_t make_packet(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] port,
        input logic [NUM_ADDR_BITS-1:0] addr,
        input logic [PAYLOAD_BITS-1:0]  payload
    );
        return {1'b1, leaf, port, addr, payload};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the slot after the last winner; the
// pointer only moves when the caller reports that the grant was taken.
module rr_arbiter #(
    parameter int N  = 6,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] last_q, last_d;
    logic          found;
    int            cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_q) + k) % N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
        last_d = advance ? grant_idx : last_q;
    end

    // Reset to the last slot so slot 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/leaf_out_packetizer.sv
// Merges the user kernel's output streams into one credited BFT packet stream.
// Handshake: a stream holds din/vld until ack pulses for one cycle; ack is combinational from the grant.
module leaf_out_packetizer
    import leaf_pkg::*;
#(
    parameter int PACKET_BITS           = leaf_pkg::PACKET_BITS,
    parameter int PAYLOAD_BITS          = leaf_pkg::PAYLOAD_BITS,
    parameter int NUM_LEAF_BITS         = leaf_pkg::NUM_LEAF_BITS,
    parameter int NUM_PORT_BITS         = leaf_pkg::NUM_PORT_BITS,
    parameter int NUM_ADDR_BITS         = leaf_pkg::NUM_ADDR_BITS,
    parameter int NUM_OUT_PORTS         = 6,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]               din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                            vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                            ack_interface2user,
    input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg,
    input  logic                                                credit_upd_vld,
    input  logic [NUM_PORT_BITS-1:0]                            credit_upd_port,
    input  logic                                                out_ready,
    input  logic                                                resend,
    output logic [PACKET_BITS-1:0]                              dout_packet
);

    localparam int IDX_BITS  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int DEST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int CRED_W    = NUM_ADDR_BITS + 1;
    localparam logic [CRED_W:0]   SUM_MAX = (CRED_W + 1)'(1 << NUM_ADDR_BITS);
    localparam logic [CRED_W:0]   UPD_INC = (CRED_W + 1)'(FREESPACE_UPDATE_SIZE);
    localparam logic [CRED_W-1:0] CRED_RST = CRED_W'(1 << NUM_ADDR_BITS);

    logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr_d   [NUM_OUT_PORTS];
    logic [CRED_W-1:0]        credit_q [NUM_OUT_PORTS];
    logic [CRED_W-1:0]        credit_d [NUM_OUT_PORTS];
    logic [PACKET_BITS-1:0]   dout_q, dout_d;

    logic [NUM_OUT_PORTS-1:0] eligible, grant;
    logic [IDX_BITS-1:0]      grant_idx;
    logic                     out_vld, can_load, fire;
    logic [DEST_BITS-1:0]     dest_sel;
    logic [PAYLOAD_BITS-1:0]  din_sel;
    logic [NUM_ADDR_BITS-1:0] addr_sel;
    logic [CRED_W:0]          sum;
    logic                     upd_hit;

    rr_arbiter #(.N(NUM_OUT_PORTS), .IW(IDX_BITS)) u_arb (
        .clk       (clk),
        .rst_n     (reset_n),
        .req       (eligible),
        .advance   (fire),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = vld_user2interface[i] && (credit_q[i] != '0);
        end
        out_vld  = dout_q[PACKET_BITS-1];
        can_load = !out_vld || out_ready;
        // Gated by reset_n so ack stays low while reset is held.
        fire     = (|grant) && !resend && can_load && reset_n;
        ack_interface2user = fire ? grant : '0;

        dest_sel = dest_cfg[grant_idx*DEST_BITS +: DEST_BITS];
        din_sel  = din_leaf_user2interface[grant_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
        addr_sel = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (IDX_BITS'(i) == grant_idx) addr_sel = addr_q[i];
        end

        if (fire) begin
            dout_d = make_packet(dest_sel[DEST_BITS-1 -: NUM_LEAF_BITS],
                                 dest_sel[NUM_PORT_BITS-1:0], addr_sel, din_sel);
        end else if (out_vld && out_ready && !resend) begin
            dout_d = '0;
        end else begin
            dout_d = dout_q;
        end

        sum     = '0;
        upd_hit = 1'b0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            addr_d[i] = addr_q[i] + NUM_ADDR_BITS'(ack_interface2user[i]);
            // Out-of-range update ports never match any stream index.
            upd_hit = credit_upd_vld && (credit_upd_port == NUM_PORT_BITS'(i));
            sum = {1'b0, credit_q[i]} + (upd_hit ? UPD_INC : '0)
                  - (CRED_W + 1)'(ack_interface2user[i]);
            credit_d[i] = (sum > SUM_MAX) ? SUM_MAX[CRED_W-1:0] : sum[CRED_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                addr_q[i]   <= '0;
                credit_q[i] <= CRED_RST;
            end
        end else begin
            dout_q   <= dout_d;
            addr_q   <= addr_d;
            credit_q <= credit_d;
        end
    end

    assign dout_packet = dout_q;

endmodule
